sw_alloc_rr: RTL and testbench

- Switch allocator for the cardinal router. Sits directly upstream of the internal crossbar.
- Consumes the per-output request vectors produced by the request matrix.
- Produces the one-hot per-output grant vectors the crossbar uses to move a packet from an input buffer to an output buffer.
- Keeps one round-robin priority pointer per output port so every input is served fairly over time.

---
 rtl/sw_alloc_rr_pkg.sv | 21 ++
 rtl/sw_alloc_rr_if.sv | 20 ++
 rtl/sw_alloc_rr_arb5.sv | 38 +++
 rtl/sw_alloc_rr.sv | 44 ++++
 tb/tb_sw_alloc_rr.sv | 95 +++++++++
 5 files changed

// File: rtl/sw_alloc_rr_pkg.sv
// sw_alloc_rr_pkg: shared router constants, packet field layout and round-robin helpers
package sw_alloc_rr_pkg;
  localparam int NPORT = 5;
  localparam int P_N = 4, P_S = 3, P_E = 2, P_W = 1, P_PE = 0;
  // 32-bit packet: vc | dx | dy | hx | hy | sx | sy | payload
  localparam int PKT_W = 32;
  localparam int CRD_W = 3;
  localparam int VC_BIT = 31;
  localparam int DX_BIT = 30;
  localparam int DY_BIT = 29;
  localparam int HX_LSB = 26;
  localparam int HY_LSB = 23;
  localparam int SX_LSB = 20;
  localparam int SY_LSB = 17;
  localparam int PL_LSB = 0;
  localparam int PL_W = 17;
  typedef logic [NPORT-1:0] pvec_t;
  function automatic logic [2:0] rr_next(input logic [2:0] w);
    return w >= 3'd4 ? 3'd0 : w + 3'd1;
  endfunction
endpackage

// File: rtl/sw_alloc_rr_if.sv
// sw_alloc_rr_if: request, buffer-full and grant bundle between request matrix, allocator and crossbar
interface sw_alloc_rr_if;
  import sw_alloc_rr_pkg::*;
  logic phase_internal;
  pvec_t req_to_n, req_to_s, req_to_e, req_to_w, req_to_pe;
  logic outbuf_full_n, outbuf_full_s, outbuf_full_e, outbuf_full_w, outbuf_full_pe;
  pvec_t gnt_to_n, gnt_to_s, gnt_to_e, gnt_to_w, gnt_to_pe;
  modport master (
    output phase_internal,
    output req_to_n, req_to_s, req_to_e, req_to_w, req_to_pe,
    output outbuf_full_n, outbuf_full_s, outbuf_full_e, outbuf_full_w, outbuf_full_pe,
    input  gnt_to_n, gnt_to_s, gnt_to_e, gnt_to_w, gnt_to_pe
  );
  modport slave (
    input  phase_internal,
    input  req_to_n, req_to_s, req_to_e, req_to_w, req_to_pe,
    input  outbuf_full_n, outbuf_full_s, outbuf_full_e, outbuf_full_w, outbuf_full_pe,
    output gnt_to_n, gnt_to_s, gnt_to_e, gnt_to_w, gnt_to_pe
  );
endinterface

// File: rtl/sw_alloc_rr_arb5.sv
// rr_arb5: 5-way round-robin arbiter, combinational one-hot grant, pointer advances past each winner
module rr_arb5
  import sw_alloc_rr_pkg::*;
#(
  parameter logic [2:0] PTR_RST = 3'd0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  pvec_t req,
  output pvec_t gnt
);
  logic [2:0] ptr, base, w, idx;
  logic [3:0] s;
  logic hit;
  // out-of-range pointers scan as if they were 0
  assign base = ptr > 3'd4 ? 3'd0 : ptr;
  always_comb begin
    gnt = '0;
    w = base;
    hit = 1'b0;
    s = '0;
    idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      s = {1'b0, base} + 4'(k);
      idx = s > 4'd4 ? 3'(s - 4'd5) : s[2:0];
      if (!hit && req[idx]) begin
        gnt[idx] = 1'b1;
        w = idx;
        hit = 1'b1;
      end
    end
    if (!(en && reset)) gnt = '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= PTR_RST;
    else if (|gnt) ptr <= ptr > 3'd4 ? 3'd0 : rr_next(w);
endmodule

// File: rtl/sw_alloc_rr.sv
// sw_alloc_rr: switch allocator, one independent round-robin arbiter per output port
module sw_alloc_rr
  import sw_alloc_rr_pkg::*;
#(
  parameter logic [2:0] PTR_RST = 3'd0
) (
  input logic clk,
  input logic reset,
  sw_alloc_rr_if.slave bus
);
  pvec_t req [NPORT];
  pvec_t gnt [NPORT];
  logic [NPORT-1:0] full, multi;
  assign req[P_N]  = bus.req_to_n;
  assign req[P_S]  = bus.req_to_s;
  assign req[P_E]  = bus.req_to_e;
  assign req[P_W]  = bus.req_to_w;
  assign req[P_PE] = bus.req_to_pe;
  assign full = {bus.outbuf_full_n, bus.outbuf_full_s, bus.outbuf_full_e, bus.outbuf_full_w, bus.outbuf_full_pe};
  genvar i;
  generate
    for (i = 0; i < NPORT; i++) begin : g_arb
      rr_arb5 #(.PTR_RST(PTR_RST)) u_arb (
        .clk(clk),
        .reset(reset),
        .en(bus.phase_internal & ~full[i]),
        .req(req[i]),
        .gnt(gnt[i])
      );
    end
  endgenerate
  assign bus.gnt_to_n  = gnt[P_N];
  assign bus.gnt_to_s  = gnt[P_S];
  assign bus.gnt_to_e  = gnt[P_E];
  assign bus.gnt_to_w  = gnt[P_W];
  assign bus.gnt_to_pe = gnt[P_PE];
  // XY routing guarantees an input targets one output; outputs would otherwise double-grant it
  always_comb begin
    multi = '0;
    for (int j = 0; j < NPORT; j++)
      multi[j] = $countones({req[4][j], req[3][j], req[2][j], req[1][j], req[0][j]}) > 1;
  end
  a_xy_single_output: assert property (@(posedge clk) disable iff (!reset) multi == '0);
endmodule

// File: tb/tb_sw_alloc_rr.sv
// tb_sw_alloc_rr: directed vectors against hand-computed round-robin grants
module tb_sw_alloc_rr;
  logic clk = 1'b0;
  logic reset;
  int nvec = 0, nerr = 0;
  sw_alloc_rr_if bus ();
  sw_alloc_rr dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rr_e [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [4:0] alt_n [4] = '{5'b00100, 5'b10000, 5'b00100, 5'b10000};

  initial begin
    reset = 1'b0;
    bus.phase_internal = 1'b1;
    {bus.req_to_n, bus.req_to_s, bus.req_to_e, bus.req_to_w, bus.req_to_pe} = '0;
    {bus.outbuf_full_n, bus.outbuf_full_s, bus.outbuf_full_e, bus.outbuf_full_w, bus.outbuf_full_pe} = '0;
    bus.req_to_e = 5'b11111;
    #2 chk("rst_gnt_e", bus.gnt_to_e, 5'b00000);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) nxt();
      chk($sformatf("rr_e%0d", i), bus.gnt_to_e, rr_e[i]);
    end
    nxt();
    bus.req_to_e = '0;
    bus.req_to_n = 5'b10100;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      chk($sformatf("alt_n%0d", i), bus.gnt_to_n, alt_n[i]);
    end
    nxt();
    bus.req_to_n = '0;
    bus.req_to_e = 5'b00101;
    bus.outbuf_full_e = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt();
      chk($sformatf("full_e%0d", i), bus.gnt_to_e, 5'b00000);
    end
    nxt();
    bus.outbuf_full_e = 1'b0;
    #1 chk("unblk_e0", bus.gnt_to_e, 5'b00100);
    nxt();
    chk("unblk_e1", bus.gnt_to_e, 5'b00001);
    nxt();
    chk("unblk_e2", bus.gnt_to_e, 5'b00100);
    nxt();
    bus.req_to_e = '0;
    bus.phase_internal = 1'b0;
    bus.req_to_n = 5'b10000;
    bus.req_to_w = 5'b00010;
    #1 chk("ph0_n", bus.gnt_to_n, 5'b00000);
    chk("ph0_w", bus.gnt_to_w, 5'b00000);
    nxt();
    bus.phase_internal = 1'b1;
    #1 chk("ph1_n", bus.gnt_to_n, 5'b10000);
    chk("ph1_w", bus.gnt_to_w, 5'b00010);
    nxt();
    bus.req_to_n = '0;
    bus.req_to_w = '0;
    bus.req_to_s = 5'b00001;
    #1 chk("s_pe", bus.gnt_to_s, 5'b00001);
    nxt();
    bus.req_to_s = 5'b01000;
    #1 chk("s_s", bus.gnt_to_s, 5'b01000);
    #1 reset = 1'b0;
    #1 chk("s_async_rst", bus.gnt_to_s, 5'b00000);
    nxt();
    reset = 1'b1;
    bus.req_to_s = 5'b01001;
    #1 chk("s_after_rst0", bus.gnt_to_s, 5'b00001);
    nxt();
    chk("s_after_rst1", bus.gnt_to_s, 5'b01000);
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
